// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: default geometry,
// requester depth constants and the stall-mask helper.
package hazard_ctrl_pkg;

    localparam int NSTAGE_DEF = 6;
    localparam int NREQ_DEF   = 2;

    localparam logic [7:0]  REQ0_DEPTH    = 8'd1;
    localparam logic [7:0]  REQ1_DEPTH    = 8'd4;
    localparam logic [15:0] REQ_DEPTH_DEF = {REQ1_DEPTH, REQ0_DEPTH};

    typedef logic [NSTAGE_DEF-1:0] stall_bus_t;

    // Bit b of mask(d) is set for every stage at or below the requested depth.
    function automatic logic stall_mask_bit(input logic [7:0] depth, input int unsigned b);
        logic in_mask;
        if ({24'd0, depth} >= b) begin
            in_mask = 1'b1;
        end else begin
            in_mask = 1'b0;
        end
        return in_mask;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller's performance counters.
module sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count qualifying cycles, sticking at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= {W{1'b0}};
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: merges stall requesters into a per-stage stall
// vector, keeps sticky flush flags, performance counters and a stall watchdog.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int                   NSTAGE      = NSTAGE_DEF,
    parameter int                   NREQ        = NREQ_DEF,
    parameter logic [8*NREQ-1:0]    REQ_DEPTH   = REQ_DEPTH_DEF,
    parameter int                   NFLUSH      = 2,
    parameter int                   CNT_W       = 16,
    parameter int                   WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [NREQ-1:0]   stall_req,
    input  logic              jmp_e,
    input  logic [NFLUSH-1:0] flush_ack,
    output logic [NSTAGE-1:0] stall,
    output logic [NFLUSH-1:0] flush,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events,
    output logic              stall_timeout
);

    localparam int               RUN_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WDOG_CYCLES);

    logic [NSTAGE-1:0] w_merge;
    logic [NSTAGE-1:0] w_stall;
    logic [NFLUSH-1:0] w_f;
    logic [NFLUSH-1:0] w_flush;
    logic              w_stalled;
    logic [RUN_W-1:0]  w_run_next;
    logic [NFLUSH-1:0] r_pend;
    logic [RUN_W-1:0]  r_run;
    logic              r_timeout;

    // OR of the depth masks of all asserted requesters; the deepest one wins.
    always_comb begin
        w_merge = {NSTAGE{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            for (int b = 0; b < NSTAGE; b++) begin
                w_merge[b] = w_merge[b]
                           | (stall_req[i] & stall_mask_bit(REQ_DEPTH[8*i +: 8], b));
            end
        end
    end

    // Reset silences the pipeline, a global not-ready freezes every stage.
    always_comb begin
        w_stall = {NSTAGE{1'b0}};
        if (rst) begin
            w_stall = {NSTAGE{1'b0}};
        end else if (!rdy) begin
            w_stall = {NSTAGE{1'b1}};
        end else begin
            w_stall = w_merge;
        end
    end

    // A jump kills every front stage; an ack in the same cycle still clears its flag.
    always_comb begin
        w_f     = {NFLUSH{1'b0}};
        w_flush = {NFLUSH{1'b0}};
        if (jmp_e) begin
            w_f = {NFLUSH{1'b1}};
        end else begin
            w_f = r_pend;
        end
        if (rst) begin
            w_flush = {NFLUSH{1'b0}};
        end else begin
            w_flush = w_f & ~flush_ack;
        end
    end

    // Pending flush flags follow the visible flush and freeze while not ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= {NFLUSH{1'b0}};
        end else if (rdy) begin
            r_pend <= w_flush;
        end else begin
            r_pend <= r_pend;
        end
    end

    assign w_stalled = rdy & (|w_stall);

    // Next run length of consecutive counted stall cycles, capped at the limit.
    always_comb begin
        w_run_next = r_run;
        if (!rdy) begin
            w_run_next = r_run;
        end else if (!(|w_stall)) begin
            w_run_next = {RUN_W{1'b0}};
        end else if (r_run != RUN_MAX) begin
            w_run_next = r_run + {{(RUN_W-1){1'b0}}, 1'b1};
        end else begin
            w_run_next = r_run;
        end
    end

    // Watchdog run counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run     <= {RUN_W{1'b0}};
            r_timeout <= 1'b0;
        end else if (rdy) begin
            r_run     <= w_run_next;
            r_timeout <= r_timeout | (w_run_next == RUN_MAX);
        end else begin
            r_run     <= r_run;
            r_timeout <= r_timeout;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stalled),
        .q   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rdy & jmp_e),
        .q   (flush_events)
    );

    assign stall         = w_stall;
    assign flush         = w_flush;
    assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic,
// compared cycle by cycle against a behavioural model.
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int WDOG  = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [1:0] stall_req;
    logic       jmp_e;
    logic [1:0] flush_ack;
    logic [5:0] stall;
    logic [1:0] flush;
    logic [3:0] stall_cycles;
    logic [3:0] flush_events;
    logic       stall_timeout;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: plain integers, not the RTL's registers.
    int depth [2] = '{1, 4};
    int m_pend    = 0;
    int m_scnt    = 0;
    int m_fcnt    = 0;
    int m_run     = 0;
    int m_tout    = 0;

    hazard_ctrl #(
        .NSTAGE(6), .NREQ(2), .REQ_DEPTH(16'h0401), .NFLUSH(2),
        .CNT_W(CNT_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req), .jmp_e(jmp_e),
        .flush_ack(flush_ack), .stall(stall), .flush(flush),
        .stall_cycles(stall_cycles), .flush_events(flush_events),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_stall(input logic r, input logic rd, input logic [1:0] req);
        int maxd;
        if (r) return 0;
        if (!rd) return 63;
        maxd = -1;
        for (int i = 0; i < 2; i++)
            if (req[i] && depth[i] > maxd) maxd = depth[i];
        if (maxd < 0) return 0;
        return (1 << (maxd + 1)) - 1;
    endfunction

    function automatic int exp_flush(input logic r, input logic j, input logic [1:0] ack);
        int f;
        if (r) return 0;
        f = j ? 3 : m_pend;
        return f & ~int'(ack) & 3;
    endfunction

    task automatic step(input logic r, input logic rd, input logic [1:0] req,
                        input logic j, input logic [1:0] ack);
        int es, ef;
        rst = r; rdy = rd; stall_req = req; jmp_e = j; flush_ack = ack;
        #1;
        es = exp_stall(r, rd, req);
        ef = exp_flush(r, j, ack);
        chk("stall", 16'(stall), 16'(es));
        chk("flush", 16'(flush), 16'(ef));
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_scnt = 0; m_fcnt = 0; m_run = 0; m_tout = 0;
        end else if (rd) begin
            m_pend = ef;
            if (es != 0) begin
                if (m_scnt < CMAX) m_scnt++;
                if (m_run < WDOG) m_run++;
                if (m_run == WDOG) m_tout = 1;
            end else begin
                m_run = 0;
            end
            if (j && m_fcnt < CMAX) m_fcnt++;
        end
        #1;
        chk("stall_cycles", 16'(stall_cycles), 16'(m_scnt));
        chk("flush_events", 16'(flush_events), 16'(m_fcnt));
        chk("stall_timeout", 16'(stall_timeout), 16'(m_tout));
        @(negedge clk);
    endtask

    initial begin
        // Reset
        step(1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        step(1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        // Stall merge
        step(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
        chk("merge_01", 16'(stall), 16'h0003);
        step(1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b11, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b01, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        // Sticky flush, acked one stage at a time
        step(1'b0, 1'b1, 2'b00, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b01);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        chk("flush_after_ack0", 16'(flush), 16'h0002);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b10);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        // Jump with same-cycle ack
        step(1'b0, 1'b1, 2'b00, 1'b1, 2'b01);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b10);
        // Freeze: pending flags and counters hold through rdy=0 even with acks
        step(1'b0, 1'b1, 2'b00, 1'b1, 2'b00);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 2'b01, 1'b0, 2'b11);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        chk("flush_after_freeze", 16'(flush), 16'h0003);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b11);
        // Saturation and watchdog
        step(1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
        chk("sat_stall_cycles", 16'(stall_cycles), 16'd15);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        chk("timeout_sticky", 16'(stall_timeout), 16'd1);
        // Reset in the middle of a stall with pending flushes
        step(1'b0, 1'b1, 2'b10, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
        step(1'b1, 1'b1, 2'b10, 1'b0, 2'b00);
        chk("rst_timeout_clear", 16'(stall_timeout), 16'd0);
        step(1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 2'($urandom_range(0, 3)));
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
